keypad_debounce: RTL and testbench



---
 rtl/keypad_pkg.sv | 33 +++
 rtl/keypad_sync.sv | 28 ++
 rtl/keypad_debounce.sv | 219 +++++++++++++++++++++
 tb/tb_keypad_debounce.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants and helpers for the keypad input conditioner.
// Contents:
//   KEY_NONE            - active-low "no key" pattern
//   IDLE..STUCK         - debounce FSM state encodings
//   one_zero(v)         - true when exactly one bit of v is low
//   zero_idx(v)         - index of the lowest low bit of v, 4'hF when none
package keypad_pkg;

    localparam logic [11:0] KEY_NONE = 12'hFFF;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ARM   = 3'd1;
    localparam logic [2:0] HELD  = 3'd2;
    localparam logic [2:0] REL   = 3'd3;
    localparam logic [2:0] STUCK = 3'd4;

    function automatic logic one_zero(input logic [11:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 12; i++)
            if (!v[i]) n++;
        return n == 1;
    endfunction

    function automatic logic [3:0] zero_idx(input logic [11:0] v);
        logic [3:0] r;
        r = 4'hF;
        for (int i = 11; i >= 0; i--)
            if (!v[i]) r = 4'(i);
        return r;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: two-flop synchroniser for the 12 asynchronous active-low key lines.
// Ports:
//   clk      - system clock
//   n_reset  - synchronous active-low reset, both stages go to all ones (no key)
//   d        - raw asynchronous key lines
//   q        - synchronised key lines
module keypad_sync
    import keypad_pkg::*;
(
    input  logic        clk,
    input  logic        n_reset,
    input  logic [11:0] d,
    output logic [11:0] q
);

    logic [11:0] s1;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            s1 <= KEY_NONE;
            q  <= KEY_NONE;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/keypad_debounce.sv
// keypad_debounce: synchronise, single-key filter and debounce a 12-key active-low keypad.
// Ports:
//   clk         - system clock
//   n_reset     - synchronous active-low reset
//   raw_keys    - asynchronous keypad lines, active-low, bit i = key i
//   user_press  - debounced active-low key vector (12'hFFF = no key), registered
//   key_strobe  - one-cycle pulse in the first cycle a new key appears on user_press
//   key_idx     - index of the low bit of user_press, 4'hF when no key
//   stuck       - held-key timeout flag, registered
// Optional feature: define KEYPAD_STUCK_DET_EN to enable held-key timeout
// detection (STUCK state); otherwise stuck is tied low and HELD never times out.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DB_CYC    = 500000,
    parameter int CNT_W     = 20,
    parameter int STUCK_CYC = 250000000,
    parameter int STK_W     = 28
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [11:0] raw_keys,
    output logic [11:0] user_press,
    output logic        key_strobe,
    output logic [3:0]  key_idx,
    output logic        stuck
);

    if (DB_CYC < 1 || CNT_W < 1 || STK_W < 1 ||
        longint'(DB_CYC) >= (longint'(1) << CNT_W) ||
        longint'(STUCK_CYC) >= (longint'(1) << STK_W)) begin : g_param_check
        $error("keypad_debounce: counter widths too small for DB_CYC/STUCK_CYC");
    end

    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(DB_CYC - 1);

    logic [11:0]      s2;
    logic [11:0]      norm;
    logic [11:0]      cand;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;

    keypad_sync u_sync (
        .clk     (clk),
        .n_reset (n_reset),
        .d       (raw_keys),
        .q       (s2)
    );

    // Anything other than a single pressed key is treated as "no key",
    // so ghosting/multi-key patterns behave like a release.
    assign norm = one_zero(s2) ? s2 : KEY_NONE;

`ifdef KEYPAD_STUCK_DET_EN
    localparam logic [STK_W-1:0] STK_END = STK_W'(STUCK_CYC - 1);

    logic [STK_W-1:0] stk_cnt;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state      <= IDLE;
            cand       <= KEY_NONE;
            cnt        <= '0;
            stk_cnt    <= '0;
            user_press <= KEY_NONE;
            key_idx    <= 4'hF;
            key_strobe <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            stk_cnt    <= '0;
            case (state)
                IDLE: begin
                    user_press <= KEY_NONE;
                    key_idx    <= 4'hF;
                    if (norm != KEY_NONE) begin
                        cand  <= norm;
                        cnt   <= '0;
                        state <= ARM;
                    end
                end
                ARM: begin
                    if (norm == KEY_NONE) begin
                        state <= IDLE;
                    end else if (norm != cand) begin
                        cand <= norm;
                        cnt  <= '0;
                    end else if (cnt == CNT_END) begin
                        state      <= HELD;
                        user_press <= cand;
                        key_idx    <= zero_idx(cand);
                        key_strobe <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    cnt <= '0;
                    if (norm != cand) begin
                        state <= REL;
                    end else if (stk_cnt == STK_END) begin
                        state      <= STUCK;
                        user_press <= KEY_NONE;
                        key_idx    <= 4'hF;
                        stuck      <= 1'b1;
                    end else begin
                        stk_cnt <= stk_cnt + 1'b1;
                    end
                end
                REL: begin
                    if (norm == cand) begin
                        state <= HELD;
                    end else if (cnt == CNT_END) begin
                        state      <= IDLE;
                        user_press <= KEY_NONE;
                        key_idx    <= 4'hF;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STUCK: begin
                    // cand tracks the live key while held; the first release
                    // edge clears it, then DB_CYC quiet cycles are counted,
                    // giving the same release latency as REL.
                    if (norm != KEY_NONE) begin
                        cand <= norm;
                        cnt  <= '0;
                    end else if (cand != KEY_NONE) begin
                        cand <= KEY_NONE;
                        cnt  <= '0;
                    end else if (cnt == CNT_END) begin
                        state <= IDLE;
                        stuck <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cand       <= KEY_NONE;
                    cnt        <= '0;
                    user_press <= KEY_NONE;
                    key_idx    <= 4'hF;
                    stuck      <= 1'b0;
                end
            endcase
        end
    end
`else
    assign stuck = 1'b0;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state      <= IDLE;
            cand       <= KEY_NONE;
            cnt        <= '0;
            user_press <= KEY_NONE;
            key_idx    <= 4'hF;
            key_strobe <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    user_press <= KEY_NONE;
                    key_idx    <= 4'hF;
                    if (norm != KEY_NONE) begin
                        cand  <= norm;
                        cnt   <= '0;
                        state <= ARM;
                    end
                end
                ARM: begin
                    if (norm == KEY_NONE) begin
                        state <= IDLE;
                    end else if (norm != cand) begin
                        cand <= norm;
                        cnt  <= '0;
                    end else if (cnt == CNT_END) begin
                        state      <= HELD;
                        user_press <= cand;
                        key_idx    <= zero_idx(cand);
                        key_strobe <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    cnt <= '0;
                    if (norm != cand) state <= REL;
                end
                REL: begin
                    if (norm == cand) begin
                        state <= HELD;
                    end else if (cnt == CNT_END) begin
                        state      <= IDLE;
                        user_press <= KEY_NONE;
                        key_idx    <= 4'hF;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cand       <= KEY_NONE;
                    cnt        <= '0;
                    user_press <= KEY_NONE;
                    key_idx    <= 4'hF;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_keypad_debounce.sv
// tb_keypad_debounce: scoreboard bench for keypad_debounce (DB_CYC=4, STUCK_CYC=32).
// Stimulus pushes each expected output event (cycle, user_press, key_idx,
// key_strobe, stuck) into a queue; a negedge monitor pops and compares on every
// output change or strobe. Raw keys change at negedge cycle c, so a press or
// release is expected to be visible at negedge c+7 (edge E0+6 with E0 = c+1).
module tb_keypad_debounce;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [11:0] raw_keys;
    logic [11:0] user_press;
    logic        key_strobe;
    logic [3:0]  key_idx;
    logic        stuck;

    keypad_debounce #(
        .DB_CYC    (4),
        .CNT_W     (3),
        .STUCK_CYC (32),
        .STK_W     (6)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .raw_keys   (raw_keys),
        .user_press (user_press),
        .key_strobe (key_strobe),
        .key_idx    (key_idx),
        .stuck      (stuck)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [11:0] up;
        logic [3:0]  idx;
        logic        stb;
        logic        stk;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  fails = 0;
    int  t;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_ev(input int c, input logic [11:0] up, input logic [3:0] idx,
                           input logic stb, input logic stk);
        ev_t e;
        e.cyc = c; e.up = up; e.idx = idx; e.stb = stb; e.stk = stk;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: any output change or strobe is an event to be matched.
    logic [11:0] p_up  = 12'hFFF;
    logic [3:0]  p_idx = 4'hF;
    logic        p_stk = 1'b0;

    always @(negedge clk) begin
        ev_t e;
        if (user_press !== p_up || key_idx !== p_idx || stuck !== p_stk || key_strobe !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: cycle %0d up=%h idx=%h stb=%b stk=%b, required none",
                         cyc, user_press, key_idx, key_strobe, stuck);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.cyc || user_press !== e.up || key_idx !== e.idx ||
                    key_strobe !== e.stb || stuck !== e.stk) begin
                    fails++;
                    $display("FAIL event: got cycle %0d up=%h idx=%h stb=%b stk=%b, required cycle %0d up=%h idx=%h stb=%b stk=%b",
                             cyc, user_press, key_idx, key_strobe, stuck,
                             e.cyc, e.up, e.idx, e.stb, e.stk);
                end
            end
        end
        p_up  = user_press;
        p_idx = key_idx;
        p_stk = stuck;
    end

    initial begin
        raw_keys = 12'hFFF;
        n_reset  = 1'b0;
        wait_cyc(3);
        chk("reset_user_press", {4'h0, user_press}, 16'h0FFF);
        chk("reset_key_idx", {12'h0, key_idx}, 16'h000F);
        chk("reset_key_strobe", {15'h0, key_strobe}, 16'h0000);
        chk("reset_stuck", {15'h0, stuck}, 16'h0000);
        n_reset = 1'b1;
        wait_cyc(5);

        // Clean press and release of key 3
        raw_keys = 12'hFF7; t = cyc;
        push_ev(t + 7, 12'hFF7, 4'd3, 1'b1, 1'b0);
        wait_cyc(20);
        raw_keys = 12'hFFF; t = cyc;
        push_ev(t + 7, 12'hFFF, 4'hF, 1'b0, 1'b0);
        wait_cyc(12);

        // Bouncing key 7, then stable
        for (int k = 0; k < 8; k++) begin
            raw_keys = k[0] ? 12'hFFF : 12'hF7F;
            wait_cyc(2);
        end
        raw_keys = 12'hF7F; t = cyc;
        push_ev(t + 7, 12'hF7F, 4'd7, 1'b1, 1'b0);
        wait_cyc(20);
        raw_keys = 12'hFFF; t = cyc;
        push_ev(t + 7, 12'hFFF, 4'hF, 1'b0, 1'b0);
        wait_cyc(12);

        // Release glitch on key 0 is ignored, then a real release
        raw_keys = 12'hFFE; t = cyc;
        push_ev(t + 7, 12'hFFE, 4'd0, 1'b1, 1'b0);
        wait_cyc(20);
        raw_keys = 12'hFFF;
        wait_cyc(2);
        raw_keys = 12'hFFE;
        wait_cyc(10);
        raw_keys = 12'hFFF; t = cyc;
        push_ev(t + 7, 12'hFFF, 4'hF, 1'b0, 1'b0);
        wait_cyc(12);

        // Two keys at once: never accepted
        raw_keys = 12'hFF6;
        wait_cyc(20);
        raw_keys = 12'hFFF;
        wait_cyc(12);

        // Reset while debouncing key 11 aborts the press
        raw_keys = 12'h7FF;
        wait_cyc(5);
        n_reset  = 1'b0;
        raw_keys = 12'hFFF;
        wait_cyc(1);
        chk("midarm_user_press", {4'h0, user_press}, 16'h0FFF);
        chk("midarm_key_idx", {12'h0, key_idx}, 16'h000F);
        chk("midarm_key_strobe", {15'h0, key_strobe}, 16'h0000);
        chk("midarm_stuck", {15'h0, stuck}, 16'h0000);
        wait_cyc(2);
        n_reset = 1'b1;
        wait_cyc(12);

        // Long hold of key 3
        raw_keys = 12'hFF7; t = cyc;
        push_ev(t + 7, 12'hFF7, 4'd3, 1'b1, 1'b0);
`ifdef KEYPAD_STUCK_DET_EN
        push_ev(t + 39, 12'hFFF, 4'hF, 1'b0, 1'b1);
`endif
        wait_cyc(60);
        raw_keys = 12'hFFF; t = cyc;
        push_ev(t + 7, 12'hFFF, 4'hF, 1'b0, 1'b0);
        wait_cyc(15);

        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            checks++;
            fails++;
            $display("FAIL missing_event: got nothing, required cycle %0d up=%h idx=%h stb=%b stk=%b",
                     e.cyc, e.up, e.idx, e.stb, e.stk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end

endmodule
